// File: rtl/writeback_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | writeback_queue_if: execute push, register-file write, hazard query |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface writeback_queue_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 4
);
  logic                       ex_valid;
  logic                       ex_ready;
  logic [REG_ADDR_WIDTH-1:0]  ex_dest;
  logic [DATA_WIDTH-1:0]      ex_result;
  logic                       wb_stall;
  logic                       wr_en;
  logic [REG_ADDR_WIDTH-1:0]  wr_dest;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic [REG_ADDR_WIDTH-1:0]  dec_rs1;
  logic [REG_ADDR_WIDTH-1:0]  dec_rs2;
  logic                       rs1_pending;
  logic                       rs2_pending;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output ex_valid, ex_dest, ex_result, wb_stall, dec_rs1, dec_rs2,
    input  ex_ready, wr_en, wr_dest, wr_data, rs1_pending, rs2_pending, count
  );

  modport slave (
    input  ex_valid, ex_dest, ex_result, wb_stall, dec_rs1, dec_rs2,
    output ex_ready, wr_en, wr_dest, wr_data, rs1_pending, rs2_pending, count
  );
endinterface
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | writeback_queue: in-order retire buffer feeding the RF write port   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module writeback_queue #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  writeback_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q [DEPTH];
  logic [DATA_WIDTH-1:0]     data_q [DEPTH];
  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_dest_q, wr_dest_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // Readiness uses the current count only, so a same-cycle pop never frees a slot.
  assign w_ready = !reset && (count_q < C_FULL);
  assign w_push  = bus.ex_valid && w_ready && (bus.ex_dest != '0);
  assign w_pop   = (count_q != '0) && !bus.wb_stall;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    valid_d   = valid_q;
    wr_en_d   = 1'b0;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;
    if (w_pop) begin
      wr_en_d         = 1'b1;
      wr_dest_d       = dest_q[head_q];
      wr_data_d       = data_q[head_q];
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (w_push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      dest_q[tail_q] <= bus.ex_dest;
      data_q[tail_q] <= bus.ex_result;
    end
  end

  // A destination stays pending until its write strobe has been presented to the RF.
  always_comb begin
    w_rs1_hit = wr_en_q && (wr_dest_q == bus.dec_rs1);
    w_rs2_hit = wr_en_q && (wr_dest_q == bus.dec_rs2);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (dest_q[i] == bus.dec_rs1)) w_rs1_hit = 1'b1;
      if (valid_q[i] && (dest_q[i] == bus.dec_rs2)) w_rs2_hit = 1'b1;
    end
  end

  assign bus.ex_ready    = w_ready;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_dest     = wr_dest_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.count       = count_q;
  assign bus.rs1_pending = !reset && (bus.dec_rs1 != '0) && w_rs1_hit;
  assign bus.rs2_pending = !reset && (bus.dec_rs2 != '0) && w_rs2_hit;
endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_writeback_queue: directed scenarios plus random queue-model check|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_writeback_queue;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int D  = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  writeback_queue_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(D)) bus ();

  writeback_queue #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: an ordered list of buffered results plus the last write presented.
  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic          m_wr_en;
  logic [AW-1:0] m_wr_dest;
  logic [DW-1:0] m_wr_data;

  function automatic logic m_pending(input logic [AW-1:0] rs);
    if (reset || rs == '0) return 1'b0;
    foreach (mq[i]) if (mq[i].dest == rs) return 1'b1;
    return m_wr_en && (m_wr_dest == rs);
  endfunction

  task automatic tick();
    bit   rdy;
    ent_t e;
    @(posedge clk);
    rdy = !reset && (mq.size() < D);
    if (reset) begin
      mq.delete();
      m_wr_en   = 1'b0;
      m_wr_dest = '0;
      m_wr_data = '0;
    end else begin
      if (mq.size() != 0 && !bus.wb_stall) begin
        m_wr_en   = 1'b1;
        m_wr_dest = mq[0].dest;
        m_wr_data = mq[0].data;
        void'(mq.pop_front());
      end else begin
        m_wr_en = 1'b0;
      end
      if (bus.ex_valid && rdy && bus.ex_dest != '0) begin
        e.dest = bus.ex_dest;
        e.data = bus.ex_result;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.ex_valid = 1'b1; bus.ex_dest = 5'd3; bus.ex_result = 64'd1;
    bus.dec_rs1 = 5'd3;
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++; if (bus.ex_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.ex_ready); end
      n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
      n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
      n_vec++; if (bus.rs1_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0", bus.rs1_pending); end
      tick();
    end
    reset = 1'b0; bus.ex_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.ex_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", bus.ex_ready); end
    tick();
  endtask

  task automatic test_single_write();
    bus.dec_rs1 = 5'd5;
    bus.ex_valid = 1'b1; bus.ex_dest = 5'd5; bus.ex_result = 64'hDEAD_BEEF;
    @(negedge clk);
    n_vec++; if (bus.ex_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", bus.ex_ready); end
    n_vec++; if (bus.rs1_pending !== 1'b0) begin n_err++; $display("FAIL single_pend_pre: got %b want 0", bus.rs1_pending); end
    tick();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_early: got %b want 0", bus.wr_en); end
    n_vec++; if (bus.rs1_pending !== 1'b1) begin n_err++; $display("FAIL single_pend_q: got %b want 1", bus.rs1_pending); end
    n_vec++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.count); end
    tick();
    @(negedge clk);
    n_vec++; if (bus.wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %b want 1", bus.wr_en); end
    n_vec++; if (bus.wr_dest !== 5'd5) begin n_err++; $display("FAIL single_wr_dest: got %0d want 5", bus.wr_dest); end
    n_vec++; if (bus.wr_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL single_wr_data: got %h want deadbeef", bus.wr_data); end
    n_vec++; if (bus.rs1_pending !== 1'b1) begin n_err++; $display("FAIL single_pend_wr: got %b want 1", bus.rs1_pending); end
    tick();
    @(negedge clk);
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_drop: got %b want 0", bus.wr_en); end
    n_vec++; if (bus.rs1_pending !== 1'b0) begin n_err++; $display("FAIL single_pend_post: got %b want 0", bus.rs1_pending); end
    tick();
  endtask

  task automatic test_full();
    bus.wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.ex_valid = 1'b1; bus.ex_dest = AW'(i); bus.ex_result = 64'(100 + i);
      @(negedge clk);
      n_vec++; if (bus.ex_ready !== 1'b1) begin n_err++; $display("FAIL full_fill_ready%0d: got %b want 1", i, bus.ex_ready); end
      tick();
    end
    bus.ex_dest = 5'd9; bus.ex_result = 64'd999;
    @(negedge clk);
    n_vec++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", bus.count); end
    n_vec++; if (bus.ex_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", bus.ex_ready); end
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL full_stall_wr: got %b want 0", bus.wr_en); end
    tick();
    // Pop and push in the same full cycle: the slot is not yet free.
    bus.wb_stall = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.ex_ready !== 1'b0) begin n_err++; $display("FAIL full_popcycle_ready: got %b want 0", bus.ex_ready); end
    tick();
    bus.ex_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_dest !== AW'(i) || bus.wr_data !== 64'(100 + i))
        begin n_err++; $display("FAIL full_drain%0d: got en=%b dest=%0d data=%0d want en=1 dest=%0d data=%0d", i, bus.wr_en, bus.wr_dest, bus.wr_data, i, 100 + i); end
      tick();
    end
    @(negedge clk);
    n_vec++; if (bus.count !== 3'd0 || bus.wr_en !== 1'b0) begin n_err++; $display("FAIL full_empty: got count=%0d en=%b want 0 0", bus.count, bus.wr_en); end
    bus.ex_valid = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.ex_ready !== 1'b1) begin n_err++; $display("FAIL full_fifth_ready: got %b want 1", bus.ex_ready); end
    tick();
    bus.ex_valid = 1'b0;
    tick();
    @(negedge clk);
    n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_dest !== 5'd9) begin n_err++; $display("FAIL full_fifth_wr: got en=%b dest=%0d want 1 9", bus.wr_en, bus.wr_dest); end
    tick();
  endtask

  task automatic test_x0();
    bus.dec_rs1 = 5'd0; bus.ex_valid = 1'b1; bus.ex_dest = 5'd0; bus.ex_result = 64'd7;
    @(negedge clk);
    n_vec++; if (bus.ex_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", bus.ex_ready); end
    tick();
    bus.ex_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL x0_count: got %0d want 0", bus.count); end
      n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL x0_wr_en: got %b want 0", bus.wr_en); end
      n_vec++; if (bus.rs1_pending !== 1'b0) begin n_err++; $display("FAIL x0_pending: got %b want 0", bus.rs1_pending); end
      tick();
    end
  endtask

  task automatic test_stream_wrap();
    int nwr;
    nwr = 0;
    bus.wb_stall = 1'b0;
    for (int c = 0; c < 13; c++) begin
      bus.ex_valid = (c < 10); bus.ex_dest = AW'(c + 1); bus.ex_result = 64'(c);
      @(negedge clk);
      if (c < 10) begin
        n_vec++; if (bus.ex_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready%0d: got %b want 1", c, bus.ex_ready); end
      end
      n_vec++; if (bus.count > 3'd1) begin n_err++; $display("FAIL stream_count%0d: got %0d want <=1", c, bus.count); end
      n_vec++; if (bus.wr_en !== (c >= 2 && c <= 11)) begin n_err++; $display("FAIL stream_en%0d: got %b want %b", c, bus.wr_en, (c >= 2 && c <= 11)); end
      if (c >= 2 && c <= 11) begin
        n_vec++; if (bus.wr_dest !== AW'(c - 1) || bus.wr_data !== 64'(c - 2))
          begin n_err++; $display("FAIL stream_wr%0d: got dest=%0d data=%0d want %0d %0d", c, bus.wr_dest, bus.wr_data, c - 1, c - 2); end
      end
      if (bus.wr_en === 1'b1) nwr++;
      tick();
    end
    n_vec++; if (nwr != 10) begin n_err++; $display("FAIL stream_total: got %0d want 10", nwr); end
  endtask

  task automatic test_midop_reset();
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ex_valid = 1'b1; bus.ex_dest = AW'(6 + i); bus.ex_result = {$urandom, $urandom};
      tick();
    end
    bus.ex_valid = 1'b0; bus.dec_rs1 = 5'd6;
    @(negedge clk);
    n_vec++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL midrst_fill: got %0d want 3", bus.count); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.ex_ready !== 1'b0 || bus.rs1_pending !== 1'b0) begin n_err++; $display("FAIL midrst_during: got ready=%b pend=%b want 0 0", bus.ex_ready, bus.rs1_pending); end
    tick();
    reset = 1'b0; bus.wb_stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++; if (bus.count !== 3'd0 || bus.wr_en !== 1'b0) begin n_err++; $display("FAIL midrst_after%0d: got count=%0d en=%b want 0 0", c, bus.count, bus.wr_en); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset        = ($urandom_range(0, 63) == 0);
      bus.ex_valid = $urandom_range(0, 1);
      bus.ex_dest  = AW'($urandom_range(0, 7));
      bus.ex_result = {$urandom, $urandom};
      bus.wb_stall = ($urandom_range(0, 3) == 0);
      bus.dec_rs1  = AW'($urandom_range(0, 7));
      bus.dec_rs2  = AW'($urandom_range(0, 7));
      @(negedge clk);
      n_vec++; if (bus.ex_ready !== (!reset && mq.size() < D)) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", c, bus.ex_ready, (!reset && mq.size() < D)); end
      n_vec++; if (bus.count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, bus.count, mq.size()); end
      n_vec++; if (bus.wr_en !== m_wr_en) begin n_err++; $display("FAIL rnd_wr_en@%0d: got %b want %b", c, bus.wr_en, m_wr_en); end
      n_vec++; if (bus.wr_dest !== m_wr_dest || bus.wr_data !== m_wr_data) begin n_err++; $display("FAIL rnd_wr@%0d: got %0d/%h want %0d/%h", c, bus.wr_dest, bus.wr_data, m_wr_dest, m_wr_data); end
      n_vec++; if (bus.rs1_pending !== m_pending(bus.dec_rs1)) begin n_err++; $display("FAIL rnd_rs1@%0d: got %b want %b", c, bus.rs1_pending, m_pending(bus.dec_rs1)); end
      n_vec++; if (bus.rs2_pending !== m_pending(bus.dec_rs2)) begin n_err++; $display("FAIL rnd_rs2@%0d: got %b want %b", c, bus.rs2_pending, m_pending(bus.dec_rs2)); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_wr_en = 1'b0; m_wr_dest = '0; m_wr_data = '0;
    reset = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_dest = '0; bus.ex_result = '0; bus.wb_stall = 1'b0;
    bus.dec_rs1 = '0; bus.dec_rs2 = '0;
    test_reset();
    test_single_write();
    test_full();
    test_x0();
    test_stream_wrap();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
